// File: rtl/tdm_demux_pkg.sv
// Shared constants and helpers for the two-channel TDM demultiplexer.
package tdm_demux_pkg;

  // Select encodings for the tagged input stream
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Width needed to count 0..depth inclusive
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO with show-ahead head word, level-based full
// detection and asynchronous active-low reset that clears storage too.
module demux_chan_fifo
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int LVLW  = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [LVLW-1:0]  level,
  output logic [WIDTH-1:0] head
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTRW-1:0]  wr_ptr_r;
  logic [PTRW-1:0]  rd_ptr_r;
  logic [LVLW-1:0]  level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full/valid come from the level so pointer equality never has to be
  // disambiguated; guarded push/pop make overflow and underflow impossible.
  always_comb begin
    full      = (level_r == LVLW'(DEPTH));
    valid     = (level_r != {LVLW{1'b0}});
    push_ok_s = push && !full;
    pop_ok_s  = pop && valid;
    level     = level_r;
    head      = mem_r[rd_ptr_r];
  end

  // Storage write at the tail; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTRW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTRW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {LVLW{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVLW'(1);
        2'b01:   level_r <= level_r - LVLW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel demultiplexer: steers a tagged valid/ready stream into two
// independent FIFOs so backpressure on one channel never blocks the other.
module tdm_demux2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int LVLW  = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [LVLW-1:0]  a_level,
  output logic [LVLW-1:0]  b_level,
  output logic             drop_err
);

  logic a_full_s;
  logic b_full_s;
  logic push_a_s;
  logic push_b_s;
  logic drop_err_r;

  // Ready reflects only the addressed channel; pushes go to that channel alone
  always_comb begin
    if (in_sel == CH_A) begin
      in_ready = !a_full_s;
    end else begin
      in_ready = !b_full_s;
    end
    push_a_s = in_valid && in_ready && (in_sel == CH_A);
    push_b_s = in_valid && in_ready && (in_sel == CH_B);
    drop_err = drop_err_r;
  end

  // Sticky diagnostic: a word was offered while its channel was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_r <= 1'b0;
    end else if (in_valid && !in_ready) begin
      drop_err_r <= 1'b1;
    end else begin
      drop_err_r <= drop_err_r;
    end
  end

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVLW(LVLW)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a_s),
    .push_data (in_data),
    .pop       (a_ready),
    .full      (a_full_s),
    .valid     (a_valid),
    .level     (a_level),
    .head      (a_data)
  );

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVLW(LVLW)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b_s),
    .push_data (in_data),
    .pop       (b_ready),
    .full      (b_full_s),
    .valid     (b_valid),
    .level     (b_level),
    .head      (b_data)
  );

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed self-checking bench for tdm_demux2 (WIDTH=4, DEPTH=2).
module tb_tdm_demux2;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int LVLW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [LVLW-1:0]  a_level;
  logic [LVLW-1:0]  b_level;
  logic             drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_level  (a_level),
    .b_level  (b_level),
    .drop_err (drop_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  initial begin
    rst_n = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0);

    // Reset with random inputs for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_value("rst_in_ready", in_ready, 1);
    check_value("rst_a_valid", a_valid, 0);
    check_value("rst_b_valid", b_valid, 0);
    check_value("rst_a_level", a_level, 0);
    check_value("rst_b_level", b_level, 0);
    check_value("rst_drop_err", drop_err, 0);
    check_value("rst_a_data", a_data, 0);
    check_value("rst_b_data", b_data, 0);
    drive(1'b0, 4'h0, 1'b0);
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Routing with both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, 4'h0, 1'b0);
    tick();
    check_value("rt1_a_valid", a_valid, 1);
    check_value("rt1_a_data", a_data, 4'h0);
    check_value("rt1_b_valid", b_valid, 0);
    drive(1'b1, 4'h1, 1'b1);
    tick();
    check_value("rt2_a_valid", a_valid, 0);
    check_value("rt2_b_valid", b_valid, 1);
    check_value("rt2_b_data", b_data, 4'h1);
    drive(1'b1, 4'h0, 1'b1);
    tick();
    check_value("rt3_b_level", b_level, 1);
    check_value("rt3_b_data", b_data, 4'h0);
    drive(1'b1, 4'h1, 1'b0);
    tick();
    check_value("rt4_a_level", a_level, 1);
    check_value("rt4_a_data", a_data, 4'h1);
    check_value("rt4_b_valid", b_valid, 0);
    drive(1'b0, 4'h0, 1'b0);
    tick();
    check_value("rt5_a_valid", a_valid, 0);
    check_value("rt5_drop_err", drop_err, 0);

    // Empty channel with ready high never underflows
    tick();
    check_value("empty_a_level", a_level, 0);
    check_value("empty_b_level", b_level, 0);

    // Fill A and backpressure
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 4'h3, 1'b0);
    tick();
    drive(1'b1, 4'h5, 1'b0);
    tick();
    drive(1'b1, 4'hb, 1'b0);
    #1;
    check_value("fill_a_level", a_level, 2);
    check_value("fill_in_ready", in_ready, 0);
    check_value("fill_a_head", a_data, 4'h3);
    tick();
    check_value("fill_drop_err", drop_err, 1);
    check_value("fill_a_level_hold", a_level, 2);

    // A full still lets B accept
    drive(1'b1, 4'h9, 1'b1);
    #1;
    check_value("indep_in_ready", in_ready, 1);
    tick();
    check_value("indep_b_valid", b_valid, 1);
    check_value("indep_b_data", b_data, 4'h9);
    check_value("indep_a_level", a_level, 2);

    // Full with pop: only the pop happens, ready returns next cycle
    a_ready = 1'b1;
    drive(1'b1, 4'hc, 1'b0);
    #1;
    check_value("fullpop_in_ready", in_ready, 0);
    tick();
    check_value("fullpop_a_level", a_level, 1);
    check_value("fullpop_a_data", a_data, 4'h5);
    check_value("fullpop_in_ready_next", in_ready, 1);

    // Simultaneous push and pop at level 1
    tick();
    check_value("pushpop_a_level", a_level, 1);
    check_value("pushpop_a_data", a_data, 4'hc);
    drive(1'b0, 4'h0, 1'b0);
    a_ready = 1'b0;

    // Bring both channels to two words, then reset asynchronously
    drive(1'b1, 4'h2, 1'b1);
    tick();
    drive(1'b1, 4'h6, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0);
    check_value("pre_rst_a_level", a_level, 2);
    check_value("pre_rst_b_level", b_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_a_valid", a_valid, 0);
    check_value("arst_b_valid", b_valid, 0);
    check_value("arst_a_level", a_level, 0);
    check_value("arst_b_level", b_level, 0);
    check_value("arst_drop_err", drop_err, 0);
    check_value("arst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check_value("post_rst_a_data", a_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
Two-channel demultiplexer and the receive end of our 2:1 select path. A tagged stream (data plus a select bit) enters on a valid/ready port, and each word is steered to channel A (sel=0) or channel B (sel=1). Each channel has its own small FIFO and valid/ready output. Backpressure on one channel never stalls traffic for the other.

Parameters:
WIDTH, 1, data width of the input and of both channels
DEPTH, 2, per-channel FIFO depth in words; power of two, at least 2
LVLW, $clog2(DEPTH+1), width of the level outputs; derived, do not override

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  input word accepted this cycle when in_valid and in_ready are both high
in_data  input  WIDTH  input word
in_sel  input  1  destination: 0 routes to A, 1 routes to B
a_valid  output  1  channel A head word valid
a_ready  input  1  channel A consumer ready
a_data  output  WIDTH  channel A head word
b_valid  output  1  channel B head word valid
b_ready  input  1  channel B consumer ready
b_data  output  WIDTH  channel B head word
a_level  output  LVLW  channel A occupancy
b_level  output  LVLW  channel B occupancy
drop_err  output  1  sticky: in_valid was high while the addressed channel was full

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time):
  - FIFOs empty; in_ready=1; a_valid=b_valid=0; a_data=b_data=0; a_level=b_level=0; drop_err=0.
  - Reset mid-transfer discards all buffered words; there is no partial state.
- in_ready = NOT full(channel selected by in_sel). It is combinational from in_sel and the FIFO levels.
- While in_valid=1 and in_ready=0, the source holds in_data and in_sel stable.
- Push: on the edge where in_valid & in_ready, in_data is written to the tail of the selected FIFO and that channel's level increments. The other channel is untouched.
- Latency: a word accepted at edge N is visible at the output (x_valid=1, x_data=word) after edge N when its FIFO was empty. Otherwise it appears in arrival order.
- Pop: on the edge where x_valid & x_ready, the head is removed and the level decrements.
- x_valid = (x_level != 0). x_data is the current head, show-ahead from registered storage.
- Same channel, push and pop in one cycle:
  - Not full: level unchanged; FIFO order preserved.
  - Full: in_ready is 0, so only the pop occurs. There is no pass-through; in_ready rises the next cycle.
- Empty channel with x_ready=1: no pop; level stays 0 and never underflows.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is decided from the level, not from pointer equality.
- drop_err is set on any cycle with in_valid=1 and in_ready=0. It is cleared only by reset. No data is lost; the flag is a diagnostic for backpressure.
- Channels are fully independent. A full A with in_sel=1 still accepts for B.

Decomposition:
- Package tdm_demux_pkg:
  - CH_A=1'b0 and CH_B=1'b1 select constants.
  - Function for LVLW computation.
- Sub-module demux_chan_fifo (WIDTH, DEPTH):
  - Synchronous FIFO with push/pop/full/level/head and the same asynchronous active-low reset.
  - Instantiated twice.
- Top level contains only the routing logic, in_ready generation and drop_err.

Test Plan:
- Reset check:
  - Stimulus: hold rst_n=0 for 3 cycles with random inputs.
  - Required: in_ready=1, a_valid=b_valid=0, a_level=b_level=0, drop_err=0.
- Routing:
  - Stimulus: push (data=0,sel=0), (1,sel=1), (0,sel=1), (1,sel=0) with a_ready=b_ready=1.
  - Required: A emits 0 then 1; B emits 1 then 0; each word appears one cycle after acceptance.
- Fill and backpressure (WIDTH=4, DEPTH=2):
  - Stimulus: a_ready=0; push 4'h3 and 4'h5 with sel=0, then present a third word with sel=0.
  - Required: a_level=2, in_ready=0, drop_err=1.
  - Follow-on: switch in_sel to 1 and push 4'h9. Required: in_ready=1 and b_data=4'h9 next cycle.
- Simultaneous push and pop:
  - Stimulus: a_level=1 (head 4'h3), a_ready=1, push 4'h7 with sel=0.
  - Required: a_level stays 1; a_data=4'h7 next cycle.
- Full with pop:
  - Stimulus: a_level=2, a_ready=1, in_valid with sel=0.
  - Required: in_ready=0 that cycle, a_level=1 after the edge, in_ready=1 the following cycle.
- Reset mid-operation:
  - Stimulus: both channels holding 2 words; assert rst_n=0 asynchronously between edges.
  - Required: a_valid, b_valid, levels and drop_err go to 0 immediately, without waiting for a clock edge.
